// File: rtl/cell_access.sv
// cell_access: sequences one cell or byte request into little-endian byte accesses on a byte-wide synchronous memory.
// Optional CELL_ACCESS_ALIGN_CHK_EN rejects misaligned cell requests with an err pulse instead of accessing memory.
module cell_access #(
    parameter int ASZ = 16,
    parameter int DSZ = 8,
    parameter int NB  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    output logic              rdy,
    input  logic              wr,
    input  logic              bsel,
    input  logic [ASZ-1:0]    addr,
    input  logic [NB*DSZ-1:0] wdata,
    output logic [NB*DSZ-1:0] rdata,
    output logic              done,
    output logic              err,
    output logic              mem_we,
    output logic [ASZ-1:0]    mem_a,
    output logic [DSZ-1:0]    mem_i,
    input  logic [DSZ-1:0]    mem_o
);
    localparam int IW = NB > 1 ? $clog2(NB) : 1;
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [IW-1:0] idx, last, cidx;
    logic [NB*DSZ-1:0] wbuf;
    logic err_r, acc, misal, at_last, cap;
    assign acc     = req && rdy;
    assign at_last = idx == last;
    assign rdy     = state == IDLE && !rst;
    assign done    = state == DONE;
    assign err     = done && err_r;
    assign mem_we  = state == WRITE;
    // mem_o carries the byte addressed one cycle earlier
    assign cap     = (state == READ && idx != '0) || state == DRAIN;
    assign cidx    = state == DRAIN ? last : idx - 1'b1;
`ifdef CELL_ACCESS_ALIGN_CHK_EN
    assign misal = !bsel && addr[IW-1:0] != '0;
`else
    assign misal = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (acc) state_nx = misal ? DONE : wr ? WRITE : READ;
            WRITE:   if (at_last) state_nx = DONE;
            READ:    if (at_last) state_nx = DRAIN;
            DRAIN:   state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            last  <= '0;
            wbuf  <= '0;
            err_r <= 1'b0;
            rdata <= '0;
            mem_a <= '0;
            mem_i <= '0;
        end else begin
            if (acc) begin
                idx   <= '0;
                last  <= bsel ? '0 : IW'(NB - 1);
                err_r <= misal;
                wbuf  <= wdata >> DSZ;
                if (!misal) mem_a <= addr;
                if (!misal && wr) mem_i <= wdata[DSZ-1:0];
                if (!misal && !wr) rdata <= '0;
            end
            if ((state == WRITE || state == READ) && !at_last) begin
                idx   <= idx + 1'b1;
                mem_a <= mem_a + 1'b1;
            end
            if (state == WRITE && !at_last) begin
                mem_i <= wbuf[DSZ-1:0];
                wbuf  <= wbuf >> DSZ;
            end
            if (cap) rdata[cidx*DSZ +: DSZ] <= mem_o;
        end
    end
endmodule

// File: tb/tb_cell_access.sv
// tb_cell_access: randomized and directed stimulus for cell_access, checked by a queue-based scoreboard.
module tb_cell_access;
    logic clk = 1'b0, rst = 1'b1, req = 1'b0, wr = 1'b0, bsel = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] wdata = '0;
    logic rdy, done, err, mem_we;
    logic [31:0] rdata;
    logic [15:0] mem_a;
    logic [7:0] mem_i, mem_o;
    logic [7:0] mem [0:65535];
    logic [7:0] ref_mem [0:65535];
    typedef struct {logic [31:0] rd; bit er; int lat; int c0;} exp_t;
    exp_t q[$];
    exp_t mon_e;
    int errors = 0, checks = 0, cyc = 0, next_free = 0, acc_cnt = 0, done_cnt = 0;
    logic [31:0] last_rd = '0;
`ifdef CELL_ACCESS_ALIGN_CHK_EN
    localparam bit ALN = 1'b1;
`else
    localparam bit ALN = 1'b0;
`endif

    cell_access dut (
        .clk(clk), .rst(rst), .req(req), .rdy(rdy), .wr(wr), .bsel(bsel),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_i(mem_i), .mem_o(mem_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_a] <= mem_i;
        mem_o <= mem[mem_a];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a request of N bytes touches addr..addr+N-1 (mod 64K), little-endian
    task automatic model_accept();
        int n = bsel ? 1 : 4;
        bit mis = ALN && !bsel && addr[1:0] != 2'b0;
        int lat = mis ? 1 : wr ? n + 1 : n + 2;
        logic [31:0] r = '0;
        if (!mis)
            for (int k = 0; k < n; k++)
                if (wr) ref_mem[addr + 16'(k)] = wdata[8*k +: 8];
                else r[8*k +: 8] = ref_mem[addr + 16'(k)];
        if (!mis && !wr) last_rd = r;
        q.push_back('{last_rd, mis, lat, cyc});
        next_free = cyc + lat + 1;
        acc_cnt++;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            next_free = 0;
        end else if (req) begin
            chk("rdy_vs_model", rdy, 32'(cyc >= next_free));
            if (cyc >= next_free) model_accept();
        end
    end

    always @(negedge clk)
        if (!rst) begin
            if (done) begin
                done_cnt++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected got=1 exp=0 cyc=%0d", cyc);
                end else begin
                    mon_e = q.pop_front();
                    chk("latency", cyc - mon_e.c0 + 1, mon_e.lat);
                    chk("err", err, 32'(mon_e.er));
                    chk("rdata", rdata, mon_e.rd);
                end
            end else chk("err_without_done", err, 0);
        end

    task automatic issue(input logic w, input logic b, input logic [15:0] a, input logic [31:0] d, input bit keep);
        int c = acc_cnt;
        wr = w; bsel = b; addr = a; wdata = d; req = 1'b1;
        for (int i = 0; i < 40 && acc_cnt == c; i++) @(negedge clk);
        if (acc_cnt == c) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got=none exp=accept a=%h", a);
        end
        if (!keep) req = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got=pending%0d exp=0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic rnd(output logic w, output logic b, output logic [15:0] a, output logic [31:0] d);
        w = 1'($urandom_range(0, 1));
        b = 1'($urandom_range(0, 1));
        a = $urandom_range(0, 1) ? 16'($urandom_range(0, 63)) : 16'hFFF0 + 16'($urandom_range(0, 15));
        d = $urandom;
    endtask

    task automatic noise(input int k);
        logic w, b;
        logic [15:0] a;
        logic [31:0] d;
        for (int i = 0; i < k; i++) begin
            rnd(w, b, a, d);
            wr = w; bsel = b; addr = a; wdata = d;
            req = $urandom_range(0, 2) == 0;
            @(negedge clk);
        end
        req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic w, b;
        logic [15:0] a, ma;
        logic [31:0] d, rd;
        logic [7:0] p2, p3;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'(i * 37 + 11);
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        chk("rst_rdy", rdy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_i", mem_i, 0);
        chk("rst_rdata", rdata, 0);
        rst = 1'b0;
        #1 chk("rdy_after_rst", rdy, 1);
        @(negedge clk);
        issue(1, 0, 16'h0010, 32'h11223344, 0); wait_idle();
        chk("cw_10", mem[16'h10], 8'h44);
        chk("cw_11", mem[16'h11], 8'h33);
        chk("cw_12", mem[16'h12], 8'h22);
        chk("cw_13", mem[16'h13], 8'h11);
        issue(0, 0, 16'h0010, 32'h0, 0); wait_idle();
        chk("cr_10", rdata, 32'h11223344);
        issue(1, 1, 16'h0012, 32'hFFFFFFA5, 0); wait_idle();
        chk("bw_10", mem[16'h10], 8'h44);
        chk("bw_11", mem[16'h11], 8'h33);
        chk("bw_12", mem[16'h12], 8'hA5);
        chk("bw_13", mem[16'h13], 8'h11);
        issue(0, 1, 16'h0012, 32'h0, 0); wait_idle();
        chk("br_12", rdata, 32'h000000A5);
        issue(1, 0, 16'hFFFE, 32'hAABBCCDD, 0); wait_idle();
        chk("wrap_fffe", mem[16'hFFFE], 8'hDD);
        chk("wrap_ffff", mem[16'hFFFF], 8'hCC);
        chk("wrap_0000", mem[16'h0000], 8'hBB);
        chk("wrap_0001", mem[16'h0001], 8'hAA);
        issue(0, 0, 16'hFFFE, 32'h0, 0); wait_idle();
        chk("wrap_read", rdata, 32'hAABBCCDD);
        ma = mem_a;
        rd = rdata;
        issue(0, 0, 16'h0013, 32'h0, 0); wait_idle();
`ifdef CELL_ACCESS_ALIGN_CHK_EN
        chk("misal_mem_a", mem_a, ma);
        chk("misal_rdata", rdata, rd);
`else
        chk("unal_rdata_changed", 32'(rdata != rd), 1);
`endif
        issue(0, 1, 16'h0013, 32'h0, 0); wait_idle();
        chk("br_13", rdata, 32'h00000011);
        for (int i = 0; i < 8; i++) begin
            rnd(w, b, a, d);
            issue(w, b, a, d, 1);
        end
        req = 1'b0;
        wait_idle();
        for (int i = 0; i < 30; i++) begin
            rnd(w, b, a, d);
            issue(w, b, a, d, 0);
            noise($urandom_range(1, 8));
            wait_idle();
        end
        chk("done_vs_accept", done_cnt, acc_cnt);
        p2 = ref_mem[16'h22];
        p3 = ref_mem[16'h23];
        issue(1, 0, 16'h0020, 32'hCAFEBABE, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_mem_we", mem_we, 0);
        chk("abort_rdy", rdy, 0);
        chk("abort_done", done, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rdy_after_abort", rdy, 1);
        ref_mem[16'h22] = p2;
        ref_mem[16'h23] = p3;
        chk("abort_20", mem[16'h20], 8'hBE);
        chk("abort_21", mem[16'h21], 8'hBA);
        chk("abort_22", mem[16'h22], p2);
        chk("abort_23", mem[16'h23], p3);
        @(negedge clk);
        issue(0, 0, 16'h0020, 32'h0, 0); wait_idle();
        for (int i = 0; i < 6; i++) begin
            rnd(w, b, a, d);
            issue(w, b, a, d, 0);
            wait_idle();
        end
        for (int i = 0; i < 64; i++) chk("mem_lo", mem[i], ref_mem[i]);
        for (int i = 65520; i < 65536; i++) chk("mem_hi", mem[i], ref_mem[i]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cell_access.md
Name: cell_access

Overview:
- Multi-byte cell access sequencer between the core's load/store path and the byte-wide synchronous memory.
- Converts one cell or byte request into a sequence of byte reads or writes on the memory port.
- Absorbs the memory's 1-cycle registered read latency.
- Assembles and splits cells little-endian, and returns a single completion pulse per request.

Parameters:
- ASZ, 16, address width (byte address; same as the memory's ASZ).
- DSZ, 8, memory data width (one byte).
- NB, 4, bytes per cell; cell width CSZ = NB*DSZ (32).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req  in  1  request valid; accepted when req && rdy.
- rdy  out  1  high only in IDLE; ready to accept a request.
- wr  in  1  1 = write, 0 = read; sampled at accept.
- bsel  in  1  1 = single byte, 0 = full cell; sampled at accept.
- addr  in  ASZ  start byte address; sampled at accept.
- wdata  in  NB*DSZ  write data; bsel uses wdata[DSZ-1:0] only.
- rdata  out  NB*DSZ  read result; byte mode is zero-extended.
- done  out  1  one-cycle completion pulse.
- err  out  1  alignment error pulse, coincident with done (see Optional Feature).
- mem_we  out  1  drives memory we.
- mem_a  out  ASZ  drives memory a.
- mem_i  out  DSZ  drives memory i.
- mem_o  in  DSZ  memory registered read data (valid the cycle after mem_a is presented).

Behaviour:
- Reset values: rdy=0 while rst is high, then 1 (IDLE); rdata=0, done=0, err=0, mem_we=0, mem_a=0, mem_i=0.
- Reset is asynchronous: asserting rst mid-operation forces IDLE and mem_we=0 immediately. Bytes already written stay written. No done is issued for the aborted request.
- Request length: N = 1 if bsel, else NB. A byte counter idx runs 0..N-1.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: on req && rdy, register addr, wdata, wr and N; clear idx.
  - wr=1 → WRITE.
  - wr=0 → READ.
  - req while not rdy is ignored; no queuing.
- WRITE, one cycle per byte:
  - mem_we=1, mem_a=base+idx, mem_i=wdata byte idx (byte 0 = bits [DSZ-1:0]).
  - After idx=N-1 → DONE.
  - Writes occupy cycles T1..TN; done is high in cycle T(N+1), where T0 is the accept cycle.
- READ, one cycle per byte:
  - mem_we=0, mem_a=base+idx.
  - The byte for idx k is captured from mem_o in the following cycle into rdata byte k.
  - After idx=N-1 → DRAIN.
- DRAIN: capture the last byte → DONE.
  - Reads: done is high in cycle T(N+2).
  - rdata is fully valid in the same cycle as done.
- DONE: done=1 for exactly one cycle, then → IDLE with rdy=1.
  - A new request can be accepted in the cycle after done.
- Read assembly:
  - rdata is cleared to 0 at accept of a read, so unused upper bytes in byte mode are 0.
  - rdata holds its value until the next read accept; writes do not disturb it.
- Address arithmetic: base+idx is modulo 2^ASZ, so a cell crossing the top of memory wraps to address 0.
- Outside WRITE: mem_we=0; mem_a and mem_i hold their last values.
- Throughput:
  - Cell read: NB+3 cycles per request including accept and done.
  - Cell write: NB+2 cycles per request.

Optional Feature:
- Macro: CELL_ACCESS_ALIGN_CHK_EN.
- Defined:
  - A cell request (bsel=0) with addr mod NB != 0 performs no memory access and mem_we stays 0.
  - The FSM goes directly IDLE → DONE.
  - done and err pulse together in cycle T1; rdata is unchanged.
  - Byte requests are never misaligned.
- Not defined:
  - err is tied to 0.
  - Unaligned cell accesses proceed byte by byte with wrap-around as above.

Test Plan:
- Cell write then read:
  - Write 0x11223344 @0x0010 → memory 0x10=44, 0x11=33, 0x12=22, 0x13=11; done at T5.
  - Read @0x0010 → rdata=0x11223344 with done at T6.
- Byte ops:
  - Byte write 0xA5 @0x0012 leaves 0x10/0x11/0x13 unchanged.
  - Byte read @0x0012 → rdata=0x000000A5, done at T3.
- Wrap, macro undefined:
  - Cell write 0xAABBCCDD @0xFFFE → 0xFFFE=DD, 0xFFFF=CC, 0x0000=BB, 0x0001=AA.
  - Read back gives 0xAABBCCDD.
- Busy / back-to-back:
  - req held high continuously → second request accepted in the cycle after the first done.
  - req pulses while busy are ignored; done count equals accept count.
- Reset mid-write:
  - Assert rst after 2 bytes of writing 0xCAFEBABE @0x0020 → mem_we drops immediately, no done.
  - 0x20=BE, 0x21=BA; 0x22/0x23 keep their prior values.
  - rdy=1 after rst deasserts.
- Align check, macro defined:
  - Cell read @0x0013 → done=err=1 at T1, no mem_a activity, rdata unchanged.
  - Byte read @0x0013 → normal result, err=0.
